// File: rtl/aes_pkg.sv
// Shared AES datapath types: AddRoundKey FSM states and the standard block size.
package aes_pkg;

   typedef enum logic [1:0] {
      ARK_IDLE = 2'd0,
      ARK_RUN  = 2'd1,
      ARK_HOLD = 2'd2
   } ark_state_t;

   localparam int AES_BLOCK_BYTES = 16;

endpackage

// File: rtl/ark_lane_xor.sv
// Combinational XOR of one LANES-byte slice of the state with the matching key slice.
module ark_lane_xor #(
   parameter int W = 8
) (
   input  logic [W-1:0] work_slice,
   input  logic [W-1:0] key_slice,
   output logic [W-1:0] lane_out
);

   assign lane_out = work_slice ^ key_slice;

endmodule

// File: rtl/aroundkey_engine.sv
// AddRoundKey engine: XORs a latched state with a latched round key, LANES bytes per beat.
// Optional ARK_ZEROIZE_EN clears the key register on the output handshake.
module aroundkey_engine
   import aes_pkg::*;
#(
   parameter int BLOCK_BYTES = AES_BLOCK_BYTES,
   parameter int LANES       = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [8*BLOCK_BYTES-1:0] in_data,
   input  logic [8*BLOCK_BYTES-1:0] in_key,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [8*BLOCK_BYTES-1:0] out_data,
   output logic                     busy
);

   localparam int DW    = 8 * BLOCK_BYTES;
   localparam int LW    = 8 * LANES;
   localparam int BEATS = BLOCK_BYTES / LANES;
   localparam int CW    = $clog2(BEATS) + 1;

   generate
      if ((LANES < 1) || (LANES > BLOCK_BYTES) || ((BLOCK_BYTES % LANES) != 0)) begin : g_lanes_chk
         $error("aroundkey_engine: LANES must divide BLOCK_BYTES");
      end
   endgenerate

   // Handshake: a transfer happens on any posedge where valid && ready are both high;
   // valid may not depend on ready, and payload is held stable until the transfer.

   ark_state_t        state_q, state_d;
   logic [CW-1:0]     cnt_q;
   logic [DW-1:0]     work_q;
   logic [DW-1:0]     key_q;
   logic [LW-1:0]     work_slice, key_slice, lane_out;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ARK_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ARK_IDLE: if (in_valid)                  state_d = ARK_RUN;
         ARK_RUN:  if (cnt_q == CW'(BEATS - 1))   state_d = ARK_HOLD;
         ARK_HOLD: if (out_ready)                 state_d = ARK_IDLE;
         default:                                 state_d = ARK_IDLE;
      endcase
   end

   assign in_ready  = (state_q == ARK_IDLE);
   assign out_valid = (state_q == ARK_HOLD);
   assign busy      = (state_q == ARK_RUN) || (state_q == ARK_HOLD);
   assign out_data  = work_q;

   // Select the slice for the current beat; the beat counter never exceeds BEATS-1 in RUN.
   always_comb begin
      work_slice = '0;
      key_slice  = '0;
      for (int b = 0; b < BEATS; b++) begin
         if (cnt_q == CW'(b)) begin
            work_slice = work_q[b*LW +: LW];
            key_slice  = key_q[b*LW +: LW];
         end
      end
   end

   ark_lane_xor #(.W(LW)) u_lane_xor (
      .work_slice (work_slice),
      .key_slice  (key_slice),
      .lane_out   (lane_out)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         work_q <= '0;
         key_q  <= '0;
      end else begin
         case (state_q)
            ARK_IDLE: begin
               if (in_valid) begin
                  work_q <= in_data;
                  key_q  <= in_key;
                  cnt_q  <= '0;
               end
            end
            ARK_RUN: begin
               for (int b = 0; b < BEATS; b++) begin
                  if (cnt_q == CW'(b)) begin
                     work_q[b*LW +: LW] <= lane_out;
                  end
               end
               cnt_q <= cnt_q + CW'(1);
            end
            ARK_HOLD: begin
`ifdef ARK_ZEROIZE_EN
               if (out_ready) begin
                  key_q <= '0;
               end
`else
               key_q <= key_q;
`endif
            end
            default: begin
               cnt_q <= '0;
            end
         endcase
      end
   end

endmodule
